led_scan_mux: RTL and testbench

LED_SCAN_MUX -- requirements
Module: led_scan_mux

---
 rtl/led_scan_pkg.sv | 13 +
 rtl/hex7seg.sv | 11 +
 rtl/led_scan_mux.sv | 131 +++++++++++++
 tb/tb_led_scan_mux.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// Shared constants for the LED scan multiplexer: hex-to-7-segment table and off level.
package led_scan_pkg;

  // Active-high gfedcba patterns; element n is the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // {dp,g,f,e,d,c,b,a} with everything dark, before output polarity is applied.
  localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/hex7seg.sv
// Pure combinational nibble to active-high gfedcba segment decoder.
module hex7seg
  import led_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = HEX7_TABLE[nibble];

endmodule

// File: rtl/led_scan_mux.sv
// Time-multiplexed 7-segment scanner with per-frame snapshot and dead time.
// Optional leading-zero blanking is built when LED_SCAN_LZB_EN is defined.
module led_scan_mux
  import led_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 4,
  parameter int DEAD           = 1,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp,
  output logic [NUM_DIGITS-1:0]         select,
  output logic [7:0]                    seg,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int C_W   = $clog2(DIV);

  logic [C_W-1:0]          c_q, c_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;

  logic                    slot_wrap;
  logic                    frame_wrap;

  always_comb begin
    c_d           = c_q;
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    slot_wrap     = (c_q == C_W'(DIV - 1));
    frame_wrap    = slot_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
    if (en) begin
      c_d = slot_wrap ? '0 : c_q + 1'b1;
      if (slot_wrap) begin
        idx_d = frame_wrap ? '0 : idx_q + 1'b1;
      end
      // Capture on the last cycle of a frame so the next frame never tears.
      if (frame_wrap) begin
        snap_digits_d = digits;
        snap_dp_d     = dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q           <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
    end else begin
      c_q           <= c_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
    end
  end

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] sel_hi;

  always_comb begin
    cur_nib = '0;
    cur_dp  = 1'b0;
    sel_hi  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = snap_digits_q[4*i +: 4];
        cur_dp    = snap_dp_q[i];
        sel_hi[i] = 1'b1;
      end
    end
  end

  logic [6:0] dec_segs;
  logic [6:0] segs_7;

  hex7seg u_hex7seg (
    .nibble (cur_nib),
    .segs   (dec_segs)
  );

`ifdef LED_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  running;
  logic                  cur_blank;

  // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    lead_zero = '0;
    running   = 1'b1;
    cur_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      running      = running && (snap_digits_q[4*i +: 4] == 4'h0);
      lead_zero[i] = running;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_blank = lead_zero[i];
      end
    end
  end

  assign segs_7 = cur_blank ? 7'h00 : dec_segs;
`else
  assign segs_7 = dec_segs;
`endif

  logic                  show;
  logic [NUM_DIGITS-1:0] sel_lvl;
  logic [7:0]            seg_lvl;

  assign show        = en && (int'(c_q) >= DEAD);
  assign sel_lvl     = show ? sel_hi : '0;
  assign seg_lvl     = show ? {cur_dp, segs_7} : SEG_OFF;
  assign select      = (SEL_ACTIVE_LOW != 0) ? ~sel_lvl : sel_lvl;
  assign seg         = (SEG_ACTIVE_LOW != 0) ? ~seg_lvl : seg_lvl;
  assign idx         = idx_q;
  assign frame_start = en && (c_q == '0) && (idx_q == '0);

endmodule

// File: tb/tb_led_scan_mux.sv
// Directed bench for led_scan_mux (4 digits, DIV=4, DEAD=1, active-high outputs).
// Expected outputs are queued per cycle by the driver and checked by a monitor.
module tb_led_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  select;
  logic [7:0]  seg;
  logic [1:0]  idx;
  logic        frame_start;

  int checks = 0;
  int failures = 0;

  // {frame_start, idx, select, seg}
  logic [14:0] exp_q[$];

`ifdef LED_SCAN_LZB_EN
  localparam logic [7:0] Z = 8'h00;
`else
  localparam logic [7:0] Z = 8'h3F;
`endif

  led_scan_mux #(
    .NUM_DIGITS     (4),
    .DIV            (4),
    .DEAD           (1),
    .SEL_ACTIVE_LOW (0),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digits      (digits),
    .dp          (dp),
    .select      (select),
    .seg         (seg),
    .idx         (idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Driver: one call is one clock cycle; inputs change 1 time unit after the edge.
  task automatic cyc(input logic r, input logic e, input logic [15:0] dv, input logic [3:0] pv,
                     input bit chk, input logic fs, input logic [1:0] ix,
                     input logic [3:0] sl, input logic [7:0] sg);
    @(posedge clk);
    #1;
    rst    = r;
    en     = e;
    digits = dv;
    dp     = pv;
    if (chk) exp_q.push_back({fs, ix, sl, sg});
  endtask

  task automatic run_slot(input logic [15:0] dv, input logic [3:0] pv, input int s,
                          input logic [7:0] sg);
    logic [3:0] one;
    one = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) cyc(1'b0, 1'b1, dv, pv, 1'b1, (s == 0), 2'(s), 4'b0000, 8'h00);
      else        cyc(1'b0, 1'b1, dv, pv, 1'b1, 1'b0, 2'(s), one << s, sg);
    end
  endtask

  // Slots below chg use (da,pa), the rest (db,pb); ex = {digit3,digit2,digit1,digit0} segs.
  task automatic run_frame(input logic [15:0] da, input logic [3:0] pa,
                           input logic [15:0] db, input logic [3:0] pb,
                           input int chg, input logic [31:0] ex);
    for (int s = 0; s < 4; s++) begin
      if (s < chg) run_slot(da, pa, s, ex[8*s +: 8]);
      else         run_slot(db, pb, s, ex[8*s +: 8]);
    end
  endtask

  // Monitor: outputs are a decode of state, so every cycle presents one result.
  initial begin
    logic [14:0] e;
    logic [14:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {frame_start, idx, select, seg};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL out t=%0t got fs=%b idx=%0d sel=%b seg=%h required fs=%b idx=%0d sel=%b seg=%h",
                   $time, got[14], got[13:12], got[11:8], got[7:0],
                   e[14], e[13:12], e[11:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with scanning disabled: all outputs idle.
    cyc(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00);
    cyc(1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00);
    cyc(1'b1, 1'b0, 16'h1234, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 8'h00);

    // First frame shows the cleared snapshot; the following ones show 1234.
    run_frame(16'h1234, 4'h0, 16'h1234, 4'h0, 4, {Z, Z, Z, 8'h3F});
    run_frame(16'h1234, 4'h0, 16'h1234, 4'h0, 4, {8'h06, 8'h5B, 8'h4F, 8'h66});
    run_frame(16'h1234, 4'h0, 16'h1234, 4'h0, 4, {8'h06, 8'h5B, 8'h4F, 8'h66});

    // Inputs change during slot 1: no tearing, new value appears next frame.
    run_frame(16'h1234, 4'h0, 16'h8888, 4'h0, 1, {8'h06, 8'h5B, 8'h4F, 8'h66});
    run_frame(16'h8888, 4'h0, 16'h8888, 4'b0101, 2, {8'h7F, 8'h7F, 8'h7F, 8'h7F});

    // Frame with dp=0101 and a 10-cycle en=0 pause in the middle of slot 2.
    run_slot(16'h0050, 4'b1000, 0, 8'hFF);
    run_slot(16'h0050, 4'b1000, 1, 8'h7F);
    cyc(1'b0, 1'b1, 16'h0050, 4'b1000, 1'b1, 1'b0, 2'd2, 4'b0000, 8'h00);
    cyc(1'b0, 1'b1, 16'h0050, 4'b1000, 1'b1, 1'b0, 2'd2, 4'b0100, 8'hFF);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 16'hFFFF, 4'hF, 1'b1, 1'b0, 2'd2, 4'b0000, 8'h00);
    end
    cyc(1'b0, 1'b1, 16'h0050, 4'b1000, 1'b1, 1'b0, 2'd2, 4'b0100, 8'hFF);
    cyc(1'b0, 1'b1, 16'h0050, 4'b1000, 1'b1, 1'b0, 2'd2, 4'b0100, 8'hFF);
    run_slot(16'h0050, 4'b1000, 3, 8'h7F);

    // 0050 with dp on digit 3; then reset lands in slot 3 of this frame.
    run_slot(16'h1234, 4'h0, 0, 8'h3F);
    run_slot(16'h1234, 4'h0, 1, 8'h6D);
    run_slot(16'h1234, 4'h0, 2, Z);
    cyc(1'b0, 1'b1, 16'h1234, 4'h0, 1'b1, 1'b0, 2'd3, 4'b0000, 8'h00);
    cyc(1'b0, 1'b1, 16'h1234, 4'h0, 1'b1, 1'b0, 2'd3, 4'b1000, Z | 8'h80);
    cyc(1'b1, 1'b1, 16'h8888, 4'h0, 1'b1, 1'b0, 2'd3, 4'b1000, Z | 8'h80);

    // Frame restarts from slot 0 with the cleared snapshot, then shows 8888.
    run_frame(16'h8888, 4'h0, 16'h8888, 4'h0, 4, {Z, Z, Z, 8'h3F});
    run_frame(16'h8888, 4'h0, 16'h8888, 4'h0, 4, {8'h7F, 8'h7F, 8'h7F, 8'h7F});

    cyc(1'b0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
